pe_multicast_ctrl: RTL and testbench

Per-PE multicast controller that sits directly upstream of one PE.
- Watches the tagged ifmap and filter buses from the global buffer.
- Captures only words whose tag matches its programmed row ID, and drops the rest by acknowledging them.
- Delivers captured words to the PE as single-cycle ifmap_enable / filter_enable pulses, gated by the PE's ready handshake.
- Bursts are limited to the configured filter size per ready phase.

---
 rtl/pe_multicast_ctrl.sv | 150 +++++++++++++++
 tb/tb_pe_multicast_ctrl.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/pe_multicast_ctrl.sv
// Per-PE multicast controller: captures tag-matched ifmap/filter words from the
// global buffer and delivers them to the PE as bounded bursts per ready phase.
module pe_multicast_ctrl #(
  parameter int BITWIDTH     = 16,
  parameter int ID_WIDTH     = 4,
  parameter int CNT_WIDTH    = 3,
  parameter int DEFAULT_SIZE = 3
) (
  input  logic                 clk,
  input  logic                 rstb,
  input  logic                 cfg_we,
  input  logic [ID_WIDTH-1:0]  cfg_id,
  input  logic [CNT_WIDTH-1:0] cfg_size,
  input  logic                 ifmap_in_valid,
  input  logic [ID_WIDTH-1:0]  ifmap_in_tag,
  input  logic [BITWIDTH-1:0]  ifmap_in_data,
  output logic                 ifmap_in_ready,
  input  logic                 filter_in_valid,
  input  logic [ID_WIDTH-1:0]  filter_in_tag,
  input  logic [BITWIDTH-1:0]  filter_in_data,
  output logic                 filter_in_ready,
  input  logic                 pe_ready,
  output logic                 ifmap_enable,
  output logic [BITWIDTH-1:0]  ifmap,
  output logic                 filter_enable,
  output logic [BITWIDTH-1:0]  filter
);

  localparam int NCH = 2;

  typedef enum logic [1:0] {
    ARMED  = 2'd0,
    STREAM = 2'd1,
    DONE   = 2'd2
  } state_t;

  logic                 cfg_valid;
  logic [ID_WIDTH-1:0]  row_id;
  logic [CNT_WIDTH-1:0] size_reg;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      cfg_valid <= 1'b0;
      row_id    <= '0;
      size_reg  <= CNT_WIDTH'(DEFAULT_SIZE);
    end else if (cfg_we) begin
      cfg_valid <= 1'b1;
      row_id    <= cfg_id;
      size_reg  <= cfg_size;
    end
  end

  // Channel 0 is ifmap, channel 1 is filter; both run the same logic.
  logic [NCH-1:0]      in_valid;
  logic [NCH-1:0]      in_ready;
  logic [NCH-1:0]      enable;
  logic [ID_WIDTH-1:0] in_tag   [NCH];
  logic [BITWIDTH-1:0] in_data  [NCH];
  logic [BITWIDTH-1:0] out_data [NCH];

  assign in_valid[0] = ifmap_in_valid;
  assign in_valid[1] = filter_in_valid;
  assign in_tag[0]   = ifmap_in_tag;
  assign in_tag[1]   = filter_in_tag;
  assign in_data[0]  = ifmap_in_data;
  assign in_data[1]  = filter_in_data;

  assign ifmap_in_ready  = in_ready[0];
  assign filter_in_ready = in_ready[1];
  assign ifmap_enable    = enable[0];
  assign filter_enable   = enable[1];
  assign ifmap           = out_data[0];
  assign filter          = out_data[1];

  generate
    for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
      state_t               state;
      state_t               state_next;
      logic [CNT_WIDTH-1:0] cnt;
      logic [CNT_WIDTH-1:0] limit;
      logic                 hold_full;
      logic [BITWIDTH-1:0]  hold_data;
      logic                 match;
      logic                 issue;
      logic                 capture;
      logic                 burst_last;
      logic                 arm_load;
      logic                 in_stream;
      logic                 en_reg;
      logic [BITWIDTH-1:0]  data_reg;

      assign match      = cfg_valid & in_valid[gi] & (in_tag[gi] == row_id);
      assign issue      = hold_full & in_stream & (cnt < limit) & pe_ready;
      assign in_ready[gi] = cfg_valid & (~match | ~hold_full | issue);
      assign capture    = match & in_ready[gi];
      // cnt < limit whenever issuing, so cnt + 1 cannot wrap here.
      assign burst_last = issue & ((cnt + CNT_WIDTH'(1)) == limit);

      always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) state <= ARMED;
        else       state <= state_next;
      end

      always_comb begin
        state_next = state;
        case (state)
          ARMED:   if (pe_ready) state_next = STREAM;
          STREAM:  if (burst_last || (cnt >= limit)) state_next = DONE;
          DONE:    if (!pe_ready) state_next = ARMED;
          default: state_next = ARMED;
        endcase
      end

      always_comb begin
        arm_load  = (state == ARMED) & pe_ready;
        in_stream = (state == STREAM);
      end

      always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
          cnt       <= '0;
          limit     <= '0;
          hold_full <= 1'b0;
          hold_data <= '0;
          en_reg    <= 1'b0;
          data_reg  <= '0;
        end else begin
          en_reg <= issue;
          if (arm_load) begin
            cnt   <= '0;
            limit <= size_reg;
          end else if (issue) begin
            cnt <= cnt + CNT_WIDTH'(1);
          end
          if (issue) data_reg <= hold_data;
          if (capture) begin
            hold_full <= 1'b1;
            hold_data <= in_data[gi];
          end else if (issue) begin
            hold_full <= 1'b0;
          end
        end
      end

      assign enable[gi]   = en_reg;
      assign out_data[gi] = data_reg;
    end
  endgenerate

endmodule

// File: tb/tb_pe_multicast_ctrl.sv
// Randomized bench for pe_multicast_ctrl against a per-channel burst-budget model.
module tb_pe_multicast_ctrl;

  localparam int BW = 16;
  localparam int IW = 4;
  localparam int CW = 3;
  localparam int NCYC = 3000;

  logic          clk = 1'b0;
  logic          rstb;
  logic          cfg_we;
  logic [IW-1:0] cfg_id;
  logic [CW-1:0] cfg_size;
  logic          v   [2];
  logic [IW-1:0] t   [2];
  logic [BW-1:0] d   [2];
  logic          pe_ready;
  logic          ifmap_in_ready, filter_in_ready;
  logic          ifmap_enable, filter_enable;
  logic [BW-1:0] ifmap, filter;

  int tests_run = 0;
  int tests_failed = 0;

  pe_multicast_ctrl #(.BITWIDTH(BW), .ID_WIDTH(IW), .CNT_WIDTH(CW), .DEFAULT_SIZE(3)) dut (
    .clk(clk), .rstb(rstb),
    .cfg_we(cfg_we), .cfg_id(cfg_id), .cfg_size(cfg_size),
    .ifmap_in_valid(v[0]), .ifmap_in_tag(t[0]), .ifmap_in_data(d[0]),
    .ifmap_in_ready(ifmap_in_ready),
    .filter_in_valid(v[1]), .filter_in_tag(t[1]), .filter_in_data(d[1]),
    .filter_in_ready(filter_in_ready),
    .pe_ready(pe_ready),
    .ifmap_enable(ifmap_enable), .ifmap(ifmap),
    .filter_enable(filter_enable), .filter(filter)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Model: each channel holds at most one word and owns a budget of words per
  // ready phase. A fresh budget opens when pe_ready is seen while not spent;
  // once spent, pe_ready must be seen low before another budget can open.
  bit          m_cfg;
  int          m_id, m_size;
  bit          m_held  [2];
  logic [BW-1:0] m_word [2];
  bit          m_open  [2];
  bit          m_spent [2];
  int          m_left  [2];
  bit          m_en    [2];
  logic [BW-1:0] m_out [2];
  bit          x_rdy   [2];
  bit          x_iss   [2];
  bit          x_match [2];

  task automatic model_reset();
    m_cfg = 0; m_id = 0; m_size = 3;
    for (int c = 0; c < 2; c++) begin
      m_held[c] = 0; m_word[c] = '0; m_open[c] = 0; m_spent[c] = 0;
      m_left[c] = 0; m_en[c] = 0; m_out[c] = '0;
    end
  endtask

  task automatic model_comb();
    for (int c = 0; c < 2; c++) begin
      x_match[c] = m_cfg && v[c] && (int'(t[c]) == m_id);
      x_iss[c]   = m_held[c] && m_open[c] && (m_left[c] > 0) && pe_ready;
      x_rdy[c]   = m_cfg && (!x_match[c] || !m_held[c] || x_iss[c]);
    end
  endtask

  task automatic model_edge();
    model_comb();
    for (int c = 0; c < 2; c++) begin
      m_en[c] = x_iss[c];
      if (x_iss[c]) m_out[c] = m_word[c];
      if (m_open[c]) begin
        if (x_iss[c]) m_left[c]--;
        if (m_left[c] == 0) begin m_open[c] = 0; m_spent[c] = 1; end
      end else if (m_spent[c]) begin
        if (!pe_ready) m_spent[c] = 0;
      end else if (pe_ready) begin
        m_open[c] = 1; m_left[c] = m_size;
      end
      if (x_match[c] && x_rdy[c]) begin m_held[c] = 1; m_word[c] = d[c]; end
      else if (x_iss[c]) m_held[c] = 0;
    end
    if (cfg_we) begin m_cfg = 1; m_id = int'(cfg_id); m_size = int'(cfg_size); end
  endtask

  task automatic check_outputs();
    check("ifmap_enable", {31'd0, ifmap_enable}, {31'd0, m_en[0]});
    check("filter_enable", {31'd0, filter_enable}, {31'd0, m_en[1]});
    check("ifmap_data", {16'd0, ifmap}, {16'd0, m_out[0]});
    check("filter_data", {16'd0, filter}, {16'd0, m_out[1]});
  endtask

  task automatic check_reset_zero(input string tag);
    check({tag, "_ifmap_enable"}, {31'd0, ifmap_enable}, 32'd0);
    check({tag, "_filter_enable"}, {31'd0, filter_enable}, 32'd0);
    check({tag, "_ifmap"}, {16'd0, ifmap}, 32'd0);
    check({tag, "_filter"}, {16'd0, filter}, 32'd0);
    check({tag, "_ifmap_in_ready"}, {31'd0, ifmap_in_ready}, 32'd0);
    check({tag, "_filter_in_ready"}, {31'd0, filter_in_ready}, 32'd0);
  endtask

  int cur_id;
  int since_reset;

  initial begin
    rstb = 1'b0; cfg_we = 0; cfg_id = '0; cfg_size = '0; pe_ready = 0;
    for (int c = 0; c < 2; c++) begin v[c] = 0; t[c] = '0; d[c] = '0; end
    model_reset();
    cur_id = 0;
    since_reset = 0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_zero("reset");
    rstb = 1'b1;

    for (int cyc = 0; cyc < NCYC; cyc++) begin
      if (cyc == 1500) begin
        // Asynchronous reset in the middle of traffic: outputs clear at once.
        rstb = 1'b0;
        #1;
        check_reset_zero("async_reset");
        model_reset();
        @(posedge clk); #1;
        check_reset_zero("reset_hold");
        rstb = 1'b1;
        since_reset = 0;
      end

      cfg_we = 0;
      if (since_reset == 15 || (since_reset > 15 && $urandom_range(0, 49) == 0)) begin
        cfg_we   = 1;
        cfg_id   = (since_reset == 15) ? '0 : IW'($urandom_range(0, 3));
        cfg_size = CW'($urandom_range(1, 7));
        cur_id   = int'(cfg_id);
      end
      if ($urandom_range(0, 5) == 0) pe_ready = ~pe_ready;
      for (int c = 0; c < 2; c++) begin
        v[c] = ($urandom_range(0, 3) != 0);
        t[c] = ($urandom_range(0, 4) < 3) ? IW'(m_cfg ? m_id : cur_id) : IW'($urandom_range(0, 15));
        d[c] = BW'($urandom);
      end

      #1;
      model_comb();
      check("ifmap_in_ready", {31'd0, ifmap_in_ready}, {31'd0, x_rdy[0]});
      check("filter_in_ready", {31'd0, filter_in_ready}, {31'd0, x_rdy[1]});
      model_edge();
      @(posedge clk); #1;
      check_outputs();
      since_reset++;
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
